// File: rtl/cpu_pkg.sv
// Shared widths, constants and the fetch entry record passed between the fetch
// front end and its skid buffer.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(PC_INC - 1'b1);
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register that parks a delivered instruction while decode
// stalls, so the single-cycle memory read data is not lost.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  fetch_entry_t data_i,
    output logic         hold_valid_o,
    output fetch_entry_t data_o
);

    logic         hold_valid_q;
    fetch_entry_t hold_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '{inst: NOP_INST, pc: '0, fault: 1'b0};
        end else if (clear_i) begin
            hold_valid_q <= 1'b0;
        end else if (load_i) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= data_i;
        end
    end

    assign hold_valid_o = hold_valid_q;
    assign data_o       = hold_data_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC sequencing, redirect handling and delivery
// of {inst, pc, fault} to decode with a valid/stall handshake.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0,
    parameter int unsigned     MEM_SIZE = 1024
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_inst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            inst_fault
);

    localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_SIZE);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_fault_q, resp_fault_d;

    logic         hold_valid;
    logic         hold_load;
    logic         hold_clear;
    fetch_entry_t hold_entry;
    fetch_entry_t mem_entry;
    fetch_entry_t src_entry;
    logic         src_valid;

    fetch_skid_buf u_skid (
        .clk          (clk),
        .reset        (reset),
        .load_i       (hold_load),
        .clear_i      (hold_clear),
        .data_i       (mem_entry),
        .hold_valid_o (hold_valid),
        .data_o       (hold_entry)
    );

    // A parked entry always takes precedence over the live memory response.
    always_comb begin
        mem_entry  = '{inst: mem_inst, pc: resp_pc_q, fault: resp_fault_q};
        src_entry  = hold_valid ? hold_entry : mem_entry;
        src_valid  = hold_valid | resp_valid_q;
        inst_valid = src_valid & ~redirect;
        inst_out   = inst_valid ? src_entry.inst : '0;
        pc_out     = inst_valid ? src_entry.pc   : '0;
        inst_fault = inst_valid & src_entry.fault;
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        if (redirect) begin
            fetch_pc_d   = redirect_pc & ALIGN_MASK;
            resp_valid_d = 1'b0;
            hold_clear   = 1'b1;
        end else if (stall) begin
            // Memory data is only present for one cycle; park it before it is overwritten.
            resp_valid_d = 1'b0;
            hold_load    = resp_valid_q & ~hold_valid;
        end else begin
            fetch_pc_d   = fetch_pc_q + PC_INC;
            resp_pc_d    = fetch_pc_q;
            resp_valid_d = 1'b1;
            resp_fault_d = (fetch_pc_q >= MEM_LIMIT);
            hold_clear   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign mem_addr = fetch_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a stream-level model predicts every cycle's
// outputs, a monitor compares them against the DUT on the falling edge.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned MEM_SIZE = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_fault;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        f;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    // Stream-level model: next pc to deliver, and whether it is still in flight.
    logic        known = 1'b0;
    logic [31:0] m_pc  = 32'h0;
    int          m_wait = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_inst    (mem_inst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_fault  (inst_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) mem_inst <= memf(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        reset = r; stall = s; redirect = d; redirect_pc = t;
        if (known) begin
            e.v    = (m_wait == 0) && !d;
            e.pc   = e.v ? m_pc : 32'h0;
            e.inst = e.v ? memf(m_pc) : 32'h0;
            e.f    = e.v && (m_pc >= MEM_SIZE);
            e.addr = (m_wait == 0) ? m_pc + 32'd4 : m_pc;
            exp_q.push_back(e);
        end
        if (r) begin
            known  = 1'b1;
            m_pc   = RESET_PC;
            m_wait = 1;
        end else if (known) begin
            if (d) begin
                m_pc   = {t[31:2], 2'b00};
                m_wait = 1;
            end else if (m_wait > 0) begin
                if (!s) m_wait = 0;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n, input logic s);
        for (int i = 0; i < n; i++) drive(1'b0, s, 1'b0, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inst_valid", {31'h0, inst_valid}, {31'h0, e.v});
                chk("pc_out",     pc_out,   e.pc);
                chk("inst_out",   inst_out, e.inst);
                chk("inst_fault", {31'h0, inst_fault}, {31'h0, e.f});
                chk("mem_addr",   mem_addr, e.addr);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] tgt;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        run(4, 1'b0);
        run(3, 1'b1);
        run(3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h40);
        run(3, 1'b0);
        run(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        run(2, 1'b1);
        run(3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h43);
        run(3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h38);
        run(4, 1'b0);
        run(2, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        run(3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(4, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = $urandom_range(0, 31) * 4;
                1:       tgt = 32'($urandom_range(52, 76));
                2:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                default: tgt = $urandom;
            endcase
            drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 8, tgt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
